// File: rtl/heart_bar_renderer.sv
// Heart life-bar sprite renderer for the VGA pixel pipeline.
// Draws ROWS bars of SLOTS hearts from a shared sprite ROM. Per-row counts
// are snapshotted on frame_start, and hearts lost since the last frame blink
// for BLINK_FRAMES frames. The visibility flag is delayed to line up with the
// ROM read so is_heart/code describe the same pixel.
module heart_bar_renderer #(
    parameter int ROWS         = 3,
    parameter int SLOTS        = 5,
    parameter int COUNT_W      = 6,
    parameter int X0           = 510,
    parameter int Y0           = 220,
    parameter int SLOT_PITCH   = 20,
    parameter int ROW_PITCH    = 40,
    parameter int SPRITE_W     = 20,
    parameter int SPRITE_H     = 20,
    parameter int ADDR_W       = 9,
    parameter int COLOR_W      = 12,
    parameter int ROM_LAT      = 1,
    parameter logic [COLOR_W-1:0] TRANSPARENT = 12'h000,
    parameter int BLINK_FRAMES = 32,
    parameter int BLINK_HALF   = 4
) (
    input  logic                     Clk,
    input  logic                     Reset_n,
    input  logic                     frame_start,
    input  logic [9:0]               DrawX,
    input  logic [9:0]               DrawY,
    input  logic [ROWS*COUNT_W-1:0]  hearts,
    input  logic [ROWS-1:0]          row_enable,
    output logic [ADDR_W-1:0]        rom_addr,
    input  logic [COLOR_W-1:0]       rom_data,
    output logic                     is_heart,
    output logic [COLOR_W-1:0]       code
);

    localparam int CNT_W = $clog2(SLOTS + 1);
    localparam int TMR_W = $clog2(BLINK_FRAMES + 1);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_BLINK = 1'b1
    } row_state_e;

    logic [CNT_W-1:0] shown_v [ROWS];
    logic [CNT_W-1:0] ghost_v [ROWS];
    logic [ROWS-1:0]  blinking;
    logic [ROWS-1:0]  blink_on;

    logic [31:0]      px;
    logic [31:0]      py;
    logic             visible;

    logic [ROM_LAT-1:0] vis_pipe_q;
    logic               is_heart_q, is_heart_d;
    logic [COLOR_W-1:0] code_q, code_d;

    // Per-row snapshot / blink bookkeeping.
    for (genvar r = 0; r < ROWS; r++) begin : g_row
        row_state_e         state_q, state_d;
        logic [CNT_W-1:0]   shown_q, shown_d;
        logic [CNT_W-1:0]   ghost_q, ghost_d;
        logic [CNT_W-1:0]   c_new;
        logic [TMR_W-1:0]   timer_q, timer_d;
        logic [TMR_W-1:0]   elapsed;
        logic [COUNT_W-1:0] raw;

        assign raw         = hearts[r*COUNT_W +: COUNT_W];
        assign c_new       = (int'(raw) > SLOTS) ? CNT_W'(SLOTS) : CNT_W'(raw);
        assign elapsed     = TMR_W'(BLINK_FRAMES) - timer_q;
        assign blink_on[r] = ((int'(elapsed) / BLINK_HALF) % 2) == 0;
        assign blinking[r] = (state_q == ST_BLINK);
        assign shown_v[r]  = shown_q;
        assign ghost_v[r]  = ghost_q;

        // Next-state: loss starts/reloads a blink; otherwise a recovery cancels it or the timer runs down.
        always_comb begin
            state_d = state_q;
            shown_d = shown_q;
            ghost_d = ghost_q;
            timer_d = timer_q;
            if (frame_start) begin
                if (c_new < shown_q) begin
                    if (state_q == ST_BLINK) begin
                        ghost_d = (ghost_q > shown_q) ? ghost_q : shown_q;
                    end else begin
                        ghost_d = shown_q;
                    end
                    shown_d = c_new;
                    timer_d = TMR_W'(BLINK_FRAMES);
                    state_d = ST_BLINK;
                end else begin
                    shown_d = c_new;
                    if (c_new >= ghost_q) begin
                        state_d = ST_IDLE;
                        ghost_d = c_new;
                        timer_d = '0;
                    end else if (state_q == ST_BLINK) begin
                        timer_d = timer_q - 1'b1;
                        if (timer_q == TMR_W'(1)) begin
                            state_d = ST_IDLE;
                            ghost_d = c_new;
                        end
                    end
                end
            end
        end

        // Row state registers.
        always_ff @(posedge Clk or negedge Reset_n) begin
            if (!Reset_n) begin
                state_q <= ST_IDLE;
                shown_q <= '0;
                ghost_q <= '0;
                timer_q <= '0;
            end else begin
                state_q <= state_d;
                shown_q <= shown_d;
                ghost_q <= ghost_d;
                timer_q <= timer_d;
            end
        end
    end

    assign px = 32'(DrawX);
    assign py = 32'(DrawY);

    // Hit decode: first (row, slot) containing the pixel drives the ROM address and visibility.
    always_comb begin
        logic hit;
        hit      = 1'b0;
        rom_addr = '0;
        visible  = 1'b0;
        for (int unsigned r = 0; r < ROWS; r++) begin
            for (int unsigned s = 0; s < SLOTS; s++) begin
                if (!hit &&
                    py >= Y0 + r*ROW_PITCH && py < Y0 + r*ROW_PITCH + SPRITE_H &&
                    px >= X0 + s*SLOT_PITCH && px < X0 + s*SLOT_PITCH + SPRITE_W) begin
                    hit      = 1'b1;
                    rom_addr = ADDR_W'((py - (Y0 + r*ROW_PITCH)) * SPRITE_W +
                                       (px - (X0 + s*SLOT_PITCH)));
                    visible  = row_enable[r] &&
                               ((s < 32'(shown_v[r])) ||
                                (blinking[r] && s < 32'(ghost_v[r]) && blink_on[r]));
                end
            end
        end
    end

    // Delay visibility by the ROM latency.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            vis_pipe_q <= '0;
        end else begin
            vis_pipe_q[0] <= visible;
            for (int unsigned i = 1; i < ROM_LAT; i++) begin
                vis_pipe_q[i] <= vis_pipe_q[i-1];
            end
        end
    end

    // Combine delayed visibility with the colour key.
    always_comb begin
        is_heart_d = vis_pipe_q[ROM_LAT-1] && (rom_data != TRANSPARENT);
        code_d     = is_heart_d ? rom_data : '0;
    end

    // Output register.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            is_heart_q <= 1'b0;
            code_q     <= '0;
        end else begin
            is_heart_q <= is_heart_d;
            code_q     <= code_d;
        end
    end

    assign is_heart = is_heart_q;
    assign code     = code_q;

endmodule
